// File: rtl/hwt_trigger_counter.sv
// rtl/hwt_trigger_counter.sv - per-lane match, saturating match counters and one-shot fire FSM
//
// Purpose:
//   Evaluates f = d & (c | a&b) & ~(a&b&c) on CHANNELS independent lanes and
//   registers each result. Each lane counts its registered matches in a
//   saturating counter. A small FSM issues a single fire pulse when any
//   lane's count reaches the programmable threshold while armed.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   en      in   arm / count enable
//   clr     in   synchronous clear of y, counters and FSM
//   a,b,c,d in   [CHANNELS] lane inputs, bit i = lane i
//   thresh  in   [CNT_W] fire threshold, 0 disables hit
//   y       out  [CHANNELS] registered per-lane match
//   cnt     out  [CHANNELS*CNT_W] lane counters, lane i at [i*CNT_W +: CNT_W]
//   hit     out  [CHANNELS] lane count >= thresh (combinational)
//   fire    out  one-cycle pulse on ARMED -> FIRED
//   fired   out  high while in FIRED
//   state   out  [2] IDLE=0, ARMED=1, FIRED=2

module hwt_trigger_counter #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  input  logic [CHANNELS-1:0]       c,
  input  logic [CHANNELS-1:0]       d,
  input  logic [CNT_W-1:0]          thresh,
  output logic [CHANNELS-1:0]       y,
  output logic [CHANNELS*CNT_W-1:0] cnt,
  output logic [CHANNELS-1:0]       hit,
  output logic                      fire,
  output logic                      fired,
  output logic [1:0]                state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0]       match;
  logic [CHANNELS-1:0]       y_q;
  logic [CHANNELS-1:0]       y_d;
  logic [CHANNELS*CNT_W-1:0] cnt_q;
  logic [CHANNELS*CNT_W-1:0] cnt_d;
  state_t                    state_q;
  logic                      fire_q;

  // Match function, all lanes in parallel.
  assign match = d & (c | (a & b)) & ~(a & b & c);
  assign y_d   = clr ? '0 : match;

  // Counters advance on the registered match, so a count lags its input by two edges.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (y_q[i]) begin
          if (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX) begin
            cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + 1'b1;
          end
        end else if (MODE == 0) begin
          cnt_d[i*CNT_W +: CNT_W] = '0;
        end
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i] = (thresh != '0) && (cnt_q[i*CNT_W +: CNT_W] >= thresh);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      cnt_q <= '0;
    end else begin
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  // fire defaults low every edge so it can only ever be a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fire_q  <= 1'b0;
    end else begin
      fire_q <= 1'b0;
      if (clr) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (en) state_q <= ST_ARMED;
          end
          ST_ARMED: begin
            if (!en) begin
              state_q <= ST_IDLE;
            end else if (|hit) begin
              state_q <= ST_FIRED;
              fire_q  <= 1'b1;
            end
          end
          ST_FIRED: begin
            state_q <= ST_FIRED;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign y     = y_q;
  assign cnt   = cnt_q;
  assign fire  = fire_q;
  assign fired = (state_q == ST_FIRED);
  assign state = state_q;

endmodule

// File: tb/tb_hwt_trigger_counter.sv
// tb/tb_hwt_trigger_counter.sv - randomized and directed bench with reference model for hwt_trigger_counter

module tb_hwt_trigger_counter;

  localparam int CH = 4;
  localparam int W0 = 8;
  localparam int W1 = 2;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic clr;
  logic [CH-1:0] a, b, c, d;
  logic [W0-1:0] th0;
  logic [W1-1:0] th1;

  logic [CH-1:0]    y0, hit0, y1, hit1;
  logic [CH*W0-1:0] cnt0;
  logic [CH*W1-1:0] cnt1;
  logic             fire0, fired0, fire1, fired1;
  logic [1:0]       state0, state1;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = consecutive/8-bit instance, 1 = cumulative/2-bit instance.
  int y_m   [2][CH];
  int cnt_m [2][CH];
  int st_m  [2];
  int fire_m[2];

  hwt_trigger_counter #(.CHANNELS(CH), .CNT_W(W0), .MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .a(a), .b(b), .c(c), .d(d), .thresh(th0),
    .y(y0), .cnt(cnt0), .hit(hit0), .fire(fire0), .fired(fired0), .state(state0)
  );

  hwt_trigger_counter #(.CHANNELS(CH), .CNT_W(W1), .MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .a(a), .b(b), .c(c), .d(d), .thresh(th1),
    .y(y1), .cnt(cnt1), .hit(hit1), .fire(fire1), .fired(fired1), .state(state1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Matching abcd codes (a is the MSB).
  function automatic int f_ref(input int av, input int bv, input int cv, input int dv);
    int code;
    code = av * 8 + bv * 4 + cv * 2 + dv;
    return (code == 3 || code == 7 || code == 11 || code == 13) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < CH; i++) begin
        y_m[k][i]   = 0;
        cnt_m[k][i] = 0;
      end
      st_m[k]   = 0;
      fire_m[k] = 0;
    end
  endtask

  function automatic int hit_ref(input int k, input int i);
    int th;
    th = (k == 0) ? int'(th0) : int'(th1);
    return (th != 0 && cnt_m[k][i] >= th) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int any_hit[2];
    int maxv[2];
    maxv[0] = (1 << W0) - 1;
    maxv[1] = (1 << W1) - 1;
    for (int k = 0; k < 2; k++) begin
      any_hit[k] = 0;
      for (int i = 0; i < CH; i++) if (hit_ref(k, i) != 0) any_hit[k] = 1;
    end
    for (int k = 0; k < 2; k++) begin
      fire_m[k] = 0;
      if (clr) begin
        for (int i = 0; i < CH; i++) begin
          y_m[k][i]   = 0;
          cnt_m[k][i] = 0;
        end
        st_m[k] = 0;
      end else begin
        for (int i = 0; i < CH; i++) begin
          if (en) begin
            if (y_m[k][i] != 0) cnt_m[k][i] = (cnt_m[k][i] + 1 > maxv[k]) ? maxv[k] : cnt_m[k][i] + 1;
            else if (k == 0)    cnt_m[k][i] = 0;
          end
          y_m[k][i] = f_ref(int'(a[i]), int'(b[i]), int'(c[i]), int'(d[i]));
        end
        if (st_m[k] == 0) begin
          if (en) st_m[k] = 1;
        end else if (st_m[k] == 1) begin
          if (!en) st_m[k] = 0;
          else if (any_hit[k] != 0) begin
            st_m[k]   = 2;
            fire_m[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < CH; i++) begin
      check($sformatf("y0[%0d]", i),   int'(y0[i]),              y_m[0][i]);
      check($sformatf("cnt0[%0d]", i), int'(cnt0[i*W0 +: W0]),   cnt_m[0][i]);
      check($sformatf("hit0[%0d]", i), int'(hit0[i]),            hit_ref(0, i));
      check($sformatf("y1[%0d]", i),   int'(y1[i]),              y_m[1][i]);
      check($sformatf("cnt1[%0d]", i), int'(cnt1[i*W1 +: W1]),   cnt_m[1][i]);
      check($sformatf("hit1[%0d]", i), int'(hit1[i]),            hit_ref(1, i));
    end
    check("fire0",  int'(fire0),  fire_m[0]);
    check("fired0", int'(fired0), (st_m[0] == 2) ? 1 : 0);
    check("state0", int'(state0), st_m[0]);
    check("fire1",  int'(fire1),  fire_m[1]);
    check("fired1", int'(fired1), (st_m[1] == 2) ? 1 : 0);
    check("state1", int'(state1), st_m[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_lane(input int i, input int code);
    a[i] = 1'((code >> 3) & 1);
    b[i] = 1'((code >> 2) & 1);
    c[i] = 1'((code >> 1) & 1);
    d[i] = 1'(code & 1);
  endtask

  task automatic clear_lanes();
    a = '0; b = '0; c = '0; d = '0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Reset asserted between edges; outputs must drop with no clock edge.
  task automatic async_reset_pulse();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int seq_c[10];
    int seq_m[8];
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    clear_lanes();
    th0 = '0; th1 = '0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Truth table on lane 0 with counting disabled.
    for (int v = 0; v < 16; v++) begin
      set_lane(0, v);
      tick();
      check("tt_state", int'(state0), 0);
    end

    // Consecutive mode on lane 2.
    clear_lanes();
    do_clr();
    en = 1'b1; th0 = 8'd3; th1 = '0;
    seq_c = '{3, 3, 0, 3, 3, 3, 0, 0, 0, 0};
    foreach (seq_c[j]) begin
      set_lane(2, seq_c[j]);
      tick();
    end
    check("consec_fired", int'(fired0), 1);
    check("consec_cnt2",  int'(cnt0[2*W0 +: W0]), 0);

    // Cumulative mode with saturation on lane 0 of the 2-bit instance.
    clear_lanes();
    th1 = '0;
    do_clr();
    seq_m = '{3, 0, 3, 3, 3, 3, 0, 0};
    foreach (seq_m[j]) begin
      set_lane(0, seq_m[j]);
      tick();
    end
    check("cum_sat", int'(cnt1[0 +: W1]), 3);
    th1 = 2'd3;
    tick();
    check("cum_fire", int'(fire1), 1);

    // clr wins over a simultaneous hit.
    clear_lanes();
    do_clr();
    th0 = 8'd1; th1 = 2'd1;
    set_lane(0, 3);
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("prio_fire",  int'(fire0), 0);
    check("prio_state", int'(state0), 0);
    tick();
    check("prio_rearm", int'(state0), 1);

    // Enable gating on lane 1.
    clear_lanes();
    th0 = 8'd3; th1 = '0;
    do_clr();
    set_lane(1, 3);
    tick();
    tick();
    tick();
    en = 1'b0;
    for (int j = 0; j < 3; j++) tick();
    check("gate_cnt",   int'(cnt0[1*W0 +: W0]), 2);
    check("gate_state", int'(state0), 0);
    en = 1'b1;
    tick();
    tick();
    check("gate_fired", int'(fired0), 1);

    // Mid-interval async reset while fired, then resume.
    set_lane(3, 13);
    for (int j = 0; j < 6; j++) tick();
    async_reset_pulse();
    check("rst_state", int'(state0), 0);
    for (int j = 0; j < 6; j++) tick();

    // Randomized run.
    for (int n = 0; n < 1500; n++) begin
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom);
      d = 4'($urandom | $urandom);
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) th0 = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) th1 = 2'($urandom_range(0, 3));
      tick();
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
